// File: rtl/shl_result_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shl_result_stage_pkg
//  Description : Shared constants and state encoding for the SHL result
//                capture stage and its helper blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package shl_result_stage_pkg;

   // Default widths: operand/result width and overflow counter width
   localparam int C_DEF_DATAWIDTH = 2;
   localparam int C_DEF_CNTWIDTH  = 8;

   // Skid buffer occupancy encoding
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // Enumerated view of the occupancy, tied to the encoding above
   typedef enum logic [1:0] {
      S_EMPTY = ST_EMPTY,
      S_ONE   = ST_ONE,
      S_TWO   = ST_TWO
   } state_t;

endpackage : shl_result_stage_pkg
`default_nettype wire

// File: rtl/shl_ovf_detect.sv
`default_nettype none
// ============================================================================
//  Module      : shl_ovf_detect
//  Description : Combinational left-shift overflow detector. Flags when any
//                set bit of a is pushed past the MSB by a << sh_amt. The
//                shift amount is treated as a full-width unsigned value.
//  Revision    : 1.0 - initial release
// ============================================================================
module shl_ovf_detect #(
   parameter int DATAWIDTH = 2
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   output logic                 ovf
);

   // Bit i of a leaves the word once sh_amt >= DATAWIDTH - i. Building a
   // per-bit "lost" mask avoids a variable shifter and naturally covers
   // sh_amt = 0 (nothing lost) and sh_amt >= DATAWIDTH (everything lost).
   logic [DATAWIDTH-1:0] w_lost_mask;
   logic [DATAWIDTH:0]   w_sh_ext;

   assign w_sh_ext = {1'b0, sh_amt};

   genvar i;
   generate
      for (i = 0; i < DATAWIDTH; i++) begin : g_lost_bit
         assign w_lost_mask[i] = (w_sh_ext >= (DATAWIDTH+1)'(DATAWIDTH - i));
      end
   endgenerate

   // Overflow when any nonzero bit of a falls inside the lost region
   assign ovf = |(a & w_lost_mask);

endmodule : shl_ovf_detect
`default_nettype wire

// File: rtl/shl_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shl_result_stage
//  Description : Registered valid/ready capture stage behind a combinational
//                SHL. Buffers up to two beats (main + skid register), tags
//                each with a left-shift overflow flag and counts delivered
//                overflow beats in a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module shl_result_stage
   import shl_result_stage_pkg::*;
#(
   parameter int DATAWIDTH = C_DEF_DATAWIDTH,
   parameter int CNTWIDTH  = C_DEF_CNTWIDTH
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   input  logic [DATAWIDTH-1:0] d,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_ovf,
   input  logic                 clr_cnt,
   output logic [CNTWIDTH-1:0]  ovf_count
);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DATAWIDTH-1:0]  r_out_data;
   logic                  r_out_ovf;
   logic [DATAWIDTH-1:0]  r_skid_data;
   logic                  r_skid_ovf;
   logic [CNTWIDTH-1:0]   r_ovf_count;

   // ------------------------------------------------------------------
   // Combinational controls
   // ------------------------------------------------------------------
   logic                  w_ovf;
   logic                  w_in_fire;
   logic                  w_out_fire;
   state_t                w_state_nxt;
   logic                  w_in_ready_nxt;
   logic                  w_out_valid_nxt;
   logic                  w_load_main_in;
   logic                  w_load_main_skid;
   logic                  w_load_skid;
   logic                  w_cnt_sat;

   // Overflow flag of the beat currently offered upstream
   shl_ovf_detect #(
      .DATAWIDTH (DATAWIDTH)
   ) u_ovf_detect (
      .a      (a),
      .sh_amt (sh_amt),
      .ovf    (w_ovf)
   );

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;
   assign w_cnt_sat  = &r_ovf_count;

   // Next-state and register-load decode for the two-entry skid buffer
   always_comb begin
      w_state_nxt      = r_state;
      w_in_ready_nxt   = r_in_ready;
      w_out_valid_nxt  = r_out_valid;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_in_fire) begin
               w_load_main_in  = 1'b1;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = S_ONE;
            end
         end
         S_ONE: begin
            if (w_in_fire && w_out_fire) begin
               // Pass-through: new beat replaces the one leaving
               w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
               // Consumer stalled: park the new beat and stop upstream
               w_load_skid    = 1'b1;
               w_in_ready_nxt = 1'b0;
               w_state_nxt    = S_TWO;
            end else if (w_out_fire) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = S_EMPTY;
            end
         end
         S_TWO: begin
            // in_ready is low here, so only the output side can move
            if (w_out_fire) begin
               w_load_main_skid = 1'b1;
               w_in_ready_nxt   = 1'b1;
               w_state_nxt      = S_ONE;
            end
         end
         default: begin
            w_state_nxt     = S_EMPTY;
            w_in_ready_nxt  = 1'b1;
            w_out_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and handshake flag registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   // Main (output) register: loads from upstream or drains the skid entry
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_out_data <= '0;
         r_out_ovf  <= 1'b0;
      end else if (w_load_main_in) begin
         r_out_data <= d;
         r_out_ovf  <= w_ovf;
      end else if (w_load_main_skid) begin
         r_out_data <= r_skid_data;
         r_out_ovf  <= r_skid_ovf;
      end
   end

   // Skid register: holds the second beat while the consumer is stalled
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_skid_data <= '0;
         r_skid_ovf  <= 1'b0;
      end else if (w_load_skid) begin
         r_skid_data <= d;
         r_skid_ovf  <= w_ovf;
      end
   end

   // Saturating count of delivered overflow beats; clear has priority
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_ovf_count <= '0;
      end else if (clr_cnt) begin
         r_ovf_count <= '0;
      end else if (w_out_fire && r_out_ovf && !w_cnt_sat) begin
         r_ovf_count <= r_ovf_count + CNTWIDTH'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;
   assign ovf_count = r_ovf_count;

endmodule : shl_result_stage
`default_nettype wire

// File: tb/tb_shl_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shl_result_stage
//  Description : Self-checking bench for shl_result_stage (DATAWIDTH=8,
//                CNTWIDTH=2). A queue-based reference model tracks buffered
//                beats, overflow flags and the saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shl_result_stage;

   localparam int DW   = 8;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] a = '0;
   logic [DW-1:0] sh_amt = '0;
   logic [DW-1:0] d = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_ovf;
   logic          clr_cnt = 1'b0;
   logic [CW-1:0] ovf_count;

   shl_result_stage #(
      .DATAWIDTH (DW),
      .CNTWIDTH  (CW)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .sh_amt    (sh_amt),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .clr_cnt   (clr_cnt),
      .ovf_count (ovf_count)
   );

   always #5 Clk = ~Clk;

   // Reference model state
   typedef struct {
      logic [DW-1:0] data;
      logic          ovf;
   } beat_t;

   beat_t m_q[$];
   int    m_cnt;
   int    n_vec = 0;
   int    n_err = 0;

   // Overflow from plain integer arithmetic: true iff the mathematically
   // exact product a * 2^sh no longer fits in DW bits
   function automatic logic ref_ovf(input int ia, input int ish);
      if (ish >= DW) return (ia != 0);
      return ((ia << ish) > ((1 << DW) - 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model's view of the buffer
   task automatic chk_outputs(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() < 2));
      chk({tag, ".ovf_count"}, 32'(ovf_count), 32'(m_cnt));
      if (m_q.size() > 0) begin
         chk({tag, ".out_data"}, 32'(out_data), 32'(m_q[0].data));
         chk({tag, ".out_ovf"},  32'(out_ovf),  32'(m_q[0].ovf));
      end
   endtask

   // One clock cycle: check, drive, advance the model, wait past the edge
   task automatic step(input string tag, input logic iv, input logic [DW-1:0] ia,
                       input logic [DW-1:0] ish, input logic ordy, input logic clr,
                       output logic acc);
      beat_t b;
      chk_outputs(tag);
      in_valid  = iv;
      a         = ia;
      sh_amt    = ish;
      d         = ia << ish;
      out_ready = ordy;
      clr_cnt   = clr;
      acc = iv && (m_q.size() < 2);
      if (m_q.size() > 0 && ordy) begin
         b = m_q.pop_front();
         if (clr) m_cnt = 0;
         else if (b.ovf && m_cnt < CMAX) m_cnt++;
      end else if (clr) begin
         m_cnt = 0;
      end
      if (acc) begin
         b.data = ia << ish;
         b.ovf  = ref_ovf(int'(ia), int'(ish));
         m_q.push_back(b);
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      Rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 8'h5A;
      sh_amt    = 8'd3;
      d         = 8'hD0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      repeat (cycles) @(posedge Clk);
      #1;
      Rst      = 1'b0;
      in_valid = 1'b0;
      m_q.delete();
      m_cnt = 0;
   endtask

   task automatic drain(input string tag);
      logic acc;
      for (int k = 0; k < 8 && m_q.size() > 0; k++)
         step(tag, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
      chk({tag, ".drained"}, 32'(m_q.size()), 32'd0);
      step(tag, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
   endtask

   // Hard time limit so a stuck run still terminates
   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      logic [DW-1:0] ra, rs;
      int guard;
      m_cnt = 0;

      // ---- Reset held 2 cycles with in_valid asserted ----
      do_reset(2);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data",  32'(out_data),  32'd0);
      chk("rst.out_ovf",   32'(out_ovf),   32'd0);
      chk("rst.ovf_count", 32'(ovf_count), 32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd1);

      // ---- Single beat, 1-cycle latency ----
      step("single", 1'b1, 8'h03, 8'd2, 1'b1, 1'b0, acc);
      chk("single.valid", 32'(out_valid), 32'd1);
      chk("single.data",  32'(out_data),  32'h0C);
      chk("single.ovf",   32'(out_ovf),   32'd0);
      step("single", 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, acc);
      chk("single.gone", 32'(out_valid), 32'd0);

      // ---- Overflow edge cases, back to back ----
      step("edge", 1'b1, 8'h81, 8'd1,   1'b1, 1'b0, acc);
      step("edge", 1'b1, 8'h01, 8'd7,   1'b1, 1'b0, acc);
      step("edge", 1'b1, 8'h01, 8'd8,   1'b1, 1'b0, acc);
      step("edge", 1'b1, 8'h00, 8'd200, 1'b1, 1'b0, acc);
      drain("edge");
      chk("edge.count", 32'(ovf_count), 32'd2);

      // ---- Backpressure: 0x11, 0x22, 0x33 with consumer stalled ----
      step("bp", 1'b1, 8'h11, 8'd0, 1'b0, 1'b0, acc);
      step("bp", 1'b1, 8'h22, 8'd0, 1'b0, 1'b0, acc);
      chk("bp.in_ready_low", 32'(in_ready), 32'd0);
      step("bp", 1'b1, 8'h33, 8'd0, 1'b0, 1'b0, acc);
      chk("bp.held_33", 32'(acc), 32'd0);
      step("bp", 1'b1, 8'h33, 8'd0, 1'b0, 1'b0, acc);
      chk("bp.stable", 32'(out_data), 32'h11);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 6) begin
         step("bp", 1'b1, 8'h33, 8'd0, 1'b1, 1'b0, acc);
         guard++;
      end
      chk("bp.accept_33", 32'(acc), 32'd1);
      drain("bp");

      // ---- Saturation and clear priority ----
      step("sat", 1'b0, 8'h00, 8'd0, 1'b1, 1'b1, acc);
      for (int k = 0; k < 5; k++)
         step("sat", 1'b1, 8'hF0, 8'd4, 1'b1, 1'b0, acc);
      drain("sat");
      chk("sat.count", 32'(ovf_count), 32'(CMAX));
      step("clr", 1'b1, 8'h80, 8'd1, 1'b0, 1'b0, acc);
      chk("clr.pending_ovf", 32'(out_ovf), 32'd1);
      step("clr", 1'b0, 8'h00, 8'd0, 1'b1, 1'b1, acc);
      chk("clr.count", 32'(ovf_count), 32'd0);

      // ---- Reset while two beats are buffered ----
      step("mid", 1'b1, 8'h44, 8'd0, 1'b0, 1'b0, acc);
      step("mid", 1'b1, 8'h55, 8'd0, 1'b0, 1'b0, acc);
      chk("mid.full", 32'(in_ready), 32'd0);
      do_reset(1);
      chk("mid.out_valid", 32'(out_valid), 32'd0);
      chk("mid.in_ready",  32'(in_ready),  32'd1);
      chk("mid.ovf_count", 32'(ovf_count), 32'd0);
      step("mid", 1'b1, 8'h07, 8'd1, 1'b1, 1'b0, acc);
      chk("mid.new_data", 32'(out_data), 32'h0E);
      step("mid", 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, acc);
      chk("mid.alone", 32'(out_valid), 32'd0);

      // ---- Randomized traffic against the model ----
      for (int k = 0; k < 400; k++) begin
         ra = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 255))
                                          : 8'($urandom_range(0, 8));
         step("rand", 1'($urandom_range(0, 1)), ra, rs,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), acc);
      end
      drain("rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_shl_result_stage
`default_nettype wire
